// File: rtl/gate_pkg.sv
// Shared definitions for the basic-gate benches: operator encoding and checker FSM states.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  localparam logic [2:0] OP_LAST = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } chk_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of an N-input basic gate, selected by operator code.
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  logic [2:0]      op,
  output logic            expected
);

  // Reserved operator codes never reach a compare, so they simply yield 0.
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      OP_NAND: expected = ~&vec;
      OP_NOR:  expected = ~|vec;
      OP_XNOR: expected = ~^vec;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector into a gate under test and compares its output with the
// reference model, reporting error count, first failing vector and pass/fail.
module gate_truth_table_checker
  import gate_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  output logic [N_IN-1:0]  vec,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int               IDX_W       = N_IN + 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'((1 << N_IN) - 1);
  localparam int               SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  chk_state_e       state, next_state;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] index;
  logic [SC_W-1:0]  settle_cnt;
  logic             expected;
  logic             mismatch;
  logic             start_ok;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .vec      (vec),
    .op       (op_q),
    .expected (expected)
  );

  assign start_ok = start && (op <= OP_LAST);
  // Case inequality so an X or Z from the gate can never be taken as a match.
  assign mismatch = (dut_y !== expected);
  assign busy     = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = APPLY;
      APPLY:   next_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE:  next_state = (index == LAST_IDX) ? DONE : APPLY;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // vec is loaded on entry to APPLY so it stays put for the whole APPLY..SAMPLE span.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q             <= 3'd0;
      index            <= '0;
      settle_cnt       <= '0;
      vec              <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            op_q             <= op;
            index            <= '0;
            vec              <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        APPLY:  settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (index != LAST_IDX) begin
            index <= index + 1'b1;
            vec   <= N_IN'(index + 1'b1);
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= !first_fail_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: three instances cover the 2-input, 3-input
// saturating and zero-settle configurations against hand-computed results.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;
  logic [2:0] op_a, op_b, op_c;
  logic use_and_a;

  logic [1:0] vec_a;  logic dut_y_a, busy_a, done_a, pass_a, ffv_a;
  logic [7:0] err_a;  logic [1:0] ffvec_a;
  logic [2:0] vec_b;  logic dut_y_b, busy_b, done_b, pass_b, ffv_b;
  logic [1:0] err_b;  logic [2:0] ffvec_b;
  logic [1:0] vec_c;  logic dut_y_c, busy_c, done_c, pass_c, ffv_c;
  logic [7:0] err_c;  logic [1:0] ffvec_c;

  assign dut_y_a = use_and_a ? (&vec_a) : (|vec_a);
  assign dut_y_b = 1'b1;
  assign dut_y_c = ^vec_c;

  gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(2), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .vec(vec_a), .dut_y(dut_y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffvec_a), .first_fail_valid(ffv_a));

  gate_truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .vec(vec_b), .dut_y(dut_y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffvec_b), .first_fail_valid(ffv_b));

  gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(0), .ERR_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .op(op_c), .vec(vec_c), .dut_y(dut_y_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ffvec_c), .first_fail_valid(ffv_c));

  int compared   = 0;
  int mismatched = 0;
  int lat, dcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic val);
    case (which)
      0:       start_a = val;
      1:       start_b = val;
      default: start_c = val;
    endcase
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Start edge is cycle 0; latency is the first cycle after which done reads high.
  task automatic run_sweep(input int which, input int restart_at, input int limit,
                           input bit chk_vec, output int latency, output int done_cnt);
    latency  = -1;
    done_cnt = 0;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    if (chk_vec) begin
      check("vec_edge0", 32'(vec_a), 32'd0);
      check("busy_edge0", 32'(busy_a), 32'd1);
    end
    for (int k = 1; k <= limit; k++) begin
      if (k == restart_at) set_start(which, 1'b1);
      @(posedge clk); #1;
      if (k == restart_at) set_start(which, 1'b0);
      if (chk_vec && k < 16) check($sformatf("vec_edge%0d", k), 32'(vec_a), 32'(k / 4));
      if (done_of(which)) begin
        done_cnt++;
        if (latency < 0) latency = k;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    op_a = 3'd0; op_b = 3'd0; op_c = 3'd0;
    use_and_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_ffv", 32'(ffv_a), 32'd0);
    check("rst_ffvec", 32'(ffvec_a), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct OR gate with op=OR
    op_a = 3'd1; use_and_a = 1'b0;
    run_sweep(0, 0, 20, 1'b1, lat, dcnt);
    check("t1_latency", 32'(lat), 32'd17);
    check("t1_done_cnt", 32'(dcnt), 32'd1);
    check("t1_pass", 32'(pass_a), 32'd1);
    check("t1_err", 32'(err_a), 32'd0);
    check("t1_ffv", 32'(ffv_a), 32'd0);
    check("t1_busy_after", 32'(busy_a), 32'd0);

    // AND gate checked as OR: mismatches at 01 and 10
    use_and_a = 1'b1;
    run_sweep(0, 0, 20, 1'b0, lat, dcnt);
    check("t2_latency", 32'(lat), 32'd17);
    check("t2_err", 32'(err_a), 32'd2);
    check("t2_ffvec", 32'(ffvec_a), 32'd1);
    check("t2_ffv", 32'(ffv_a), 32'd1);
    check("t2_pass", 32'(pass_a), 32'd0);

    // Reserved op in IDLE: no sweep, results held
    op_a = 3'd6; start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("t4r_busy%0d", i), 32'(busy_a), 32'd0);
    end
    op_a = 3'd7;
    @(posedge clk); #1;
    check("t4r_busy_op7", 32'(busy_a), 32'd0);
    start_a = 1'b0;
    check("t4r_err", 32'(err_a), 32'd2);
    check("t4r_pass", 32'(pass_a), 32'd0);
    check("t4r_ffv", 32'(ffv_a), 32'd1);
    check("t4r_ffvec", 32'(ffvec_a), 32'd1);
    check("t4r_done", 32'(done_a), 32'd0);

    // Start pulsed again during vector 2: sweep unchanged, single done
    op_a = 3'd1; use_and_a = 1'b0;
    run_sweep(0, 9, 24, 1'b0, lat, dcnt);
    check("t4_latency", 32'(lat), 32'd17);
    check("t4_done_cnt", 32'(dcnt), 32'd1);
    check("t4_pass", 32'(pass_a), 32'd1);
    check("t4_err", 32'(err_a), 32'd0);

    // 3-input, 2-bit counter, stuck-at-1 gate checked as AND
    op_b = 3'd0;
    run_sweep(1, 0, 36, 1'b0, lat, dcnt);
    check("t3_latency", 32'(lat), 32'd33);
    check("t3_done_cnt", 32'(dcnt), 32'd1);
    check("t3_err_sat", 32'(err_b), 32'd3);
    check("t3_ffvec", 32'(ffvec_b), 32'd0);
    check("t3_ffv", 32'(ffv_b), 32'd1);
    check("t3_pass", 32'(pass_b), 32'd0);

    // Zero settle, XOR gate
    op_c = 3'd2;
    run_sweep(2, 0, 12, 1'b0, lat, dcnt);
    check("t6_latency", 32'(lat), 32'd9);
    check("t6_done_cnt", 32'(dcnt), 32'd1);
    check("t6_pass", 32'(pass_c), 32'd1);
    check("t6_err", 32'(err_c), 32'd0);

    // Reset during SETTLE of vector 2 with one mismatch already counted
    op_a = 3'd1; use_and_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("t5_vec_pre", 32'(vec_a), 32'd2);
    check("t5_busy_pre", 32'(busy_a), 32'd1);
    check("t5_err_pre", 32'(err_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_vec_rst", 32'(vec_a), 32'd0);
    check("t5_busy_rst", 32'(busy_a), 32'd0);
    check("t5_err_rst", 32'(err_a), 32'd0);
    check("t5_ffv_rst", 32'(ffv_a), 32'd0);
    check("t5_pass_rst", 32'(pass_a), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_a) dcnt++;
    end
    check("t5_no_done", 32'(dcnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    use_and_a = 1'b0;
    run_sweep(0, 0, 20, 1'b1, lat, dcnt);
    check("t5_latency", 32'(lat), 32'd17);
    check("t5_done_cnt", 32'(dcnt), 32'd1);
    check("t5_pass", 32'(pass_a), 32'd1);
    check("t5_err", 32'(err_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
